// File: rtl/mips_mem_pkg.sv
// +-----------------------------------------------------------------------------+
// | mips_mem_pkg: sequencer state encoding, data-segment bounds, byte lane pick |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [31:0] DATA_BEGIN_DEF = 32'h0040_0000;
  localparam logic [31:0] DATA_END_DEF   = 32'h0041_0F03;
  localparam int          MAX_LEN_DEF    = 1024;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] bo);
    logic [7:0] b;
    case (bo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_mux.sv
// +-----------------------------------------------------------------------------+
// | dmem_port_mux: data_memory port arbiter, pipeline MEM stage over sequencer  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dmem_port_mux (
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        seq_read,
  input  logic [31:0] seq_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata
);

  logic w_cpu_active;
  assign w_cpu_active = cpu_mem_read | cpu_mem_write;

  always_comb begin
    mem_read  = cpu_mem_read;
    mem_write = cpu_mem_write;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (!w_cpu_active && seq_read) begin
      mem_read  = 1'b1;
      mem_write = 1'b0;
      mem_addr  = seq_addr;
      mem_wdata = 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/syscall_string_seq.sv
// +-----------------------------------------------------------------------------+
// | syscall_string_seq: streams a NUL-terminated string from data memory        |
// | to the console while stalling the CPU.  Revision: 1.0                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module syscall_string_seq
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] DATA_BEGIN = DATA_BEGIN_DEF,
  parameter logic [31:0] DATA_END   = DATA_END_DEF,
  parameter int          MAX_LEN    = MAX_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a0,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        stall_cpu,
  output logic        busy,
  output logic        done,
  output logic        err
);

  seq_state_t  r_state, w_next;
  logic [31:0] r_ptr, r_wbuf, r_count;
  logic        r_err;

  logic        w_seq_read, w_load_start, w_load_wbuf, w_advance, w_set_err;
  logic        w_cpu_active, w_in_range;
  logic [7:0]  w_byte;

  assign w_cpu_active = cpu_mem_read | cpu_mem_write;
  assign w_in_range   = (r_ptr >= DATA_BEGIN) && (r_ptr <= DATA_END);
  assign w_byte       = byte_lane(r_wbuf, r_ptr[1:0]);

  always_comb begin
    w_next       = r_state;
    w_seq_read   = 1'b0;
    w_load_start = 1'b0;
    w_load_wbuf  = 1'b0;
    w_advance    = 1'b0;
    w_set_err    = 1'b0;
    char_valid   = 1'b0;
    char_data    = 8'd0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load_start = 1'b1;
          w_next       = FETCH;
        end
      end
      FETCH: begin
        // An out-of-range pointer never touches memory.
        if (!w_in_range) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end else begin
          w_seq_read = 1'b1;
          if (!w_cpu_active) begin
            w_load_wbuf = 1'b1;
            w_next      = EMIT;
          end
        end
      end
      EMIT: begin
        if (w_byte == 8'd0) begin
          w_next = DONE;
        end else begin
          char_valid = 1'b1;
          char_data  = w_byte;
          if (char_ready) begin
            w_advance = 1'b1;
            if (r_count + 32'd1 == 32'(MAX_LEN)) begin
              w_set_err = 1'b1;
              w_next    = DONE;
            end else if (r_ptr[1:0] == 2'd3) begin
              w_next = FETCH;
            end
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 32'd0;
      r_wbuf  <= 32'd0;
      r_count <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_start) begin
        r_ptr   <= a0;
        r_count <= 32'd0;
        r_err   <= 1'b0;
      end
      if (w_load_wbuf) r_wbuf <= mem_rdata;
      if (w_advance) begin
        r_ptr   <= r_ptr + 32'd1;
        r_count <= r_count + 32'd1;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign busy      = (r_state != IDLE);
  assign stall_cpu = busy;
  assign err       = r_err;

  dmem_port_mux u_mux (
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .seq_read     (w_seq_read),
    .seq_addr     ({r_ptr[31:2], 2'b00}),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_syscall_string_seq.sv
// +-----------------------------------------------------------------------------+
// | tb_syscall_string_seq: scoreboard bench for the print-string sequencer      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_syscall_string_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start4 = 1'b0;
  logic [31:0] a0 = 32'd0;
  logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic        char_ready = 1'b0;

  logic [31:0] mem_rdata, mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [7:0]  char_data;
  logic        char_valid, stall_cpu, busy, done, err;

  logic [31:0] m4_rdata, m4_addr, m4_wdata;
  logic        m4_read, m4_write;
  logic [7:0]  c4_data;
  logic        c4_valid, stall4, busy4, done4, err4;

  logic [31:0] mem [0:1023];

  logic [7:0]  exp_chr[$];
  logic        exp_err[$];
  logic [31:0] exp_rd[$];
  logic [7:0]  exp4_chr[$];
  logic        exp4_err[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  // Memory model covers 0x0041_0000..0x0041_0FFF; anything else reads as a marker word.
  always_comb begin
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_addr[31:12] == 20'h00410) mem_rdata = mem[mem_addr[11:2]];
  end
  always_comb begin
    m4_rdata = 32'hDEAD_BEEF;
    if (m4_addr[31:12] == 20'h00410) m4_rdata = mem[m4_addr[11:2]];
  end

  syscall_string_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a0(a0),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .stall_cpu(stall_cpu), .busy(busy), .done(done), .err(err)
  );

  syscall_string_seq #(.MAX_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a0(a0),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mem_rdata(m4_rdata),
    .mem_read(m4_read), .mem_write(m4_write), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
    .char_data(c4_data), .char_valid(c4_valid), .char_ready(char_ready),
    .stall_cpu(stall4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Monitor: pops the scoreboard whenever either DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid && char_ready) begin
        if (exp_chr.size() == 0) unexpected("char", char_data);
        else chk("char", char_data, exp_chr.pop_front());
      end
      if (done) begin
        if (exp_err.size() == 0) unexpected("done", err);
        else chk("err at done", err, exp_err.pop_front());
      end
      if (mem_read && !cpu_mem_read && !cpu_mem_write) begin
        if (exp_rd.size() == 0) unexpected("seq read", mem_addr);
        else chk("read addr", mem_addr, exp_rd.pop_front());
      end
      if (c4_valid && char_ready) begin
        if (exp4_chr.size() == 0) unexpected("char4", c4_data);
        else chk("char4", c4_data, exp4_chr.pop_front());
      end
      if (done4) begin
        if (exp4_err.size() == 0) unexpected("done4", err4);
        else chk("err4 at done", err4, exp4_err.pop_front());
      end
    end
  end

  task automatic pulse_start(input logic [31:0] addr, input bit which);
    @(posedge clk); #1;
    a0 = addr;
    if (which) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = which ? done4 : done;
    end
    if (!seen) unexpected("done timeout", n);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = char_valid;
    end
    if (!seen) unexpected("char_valid timeout", n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10'h080] = 32'h0000_6948;   // "Hi"     @0x0041_0200
    mem[10'h0C0] = 32'h007A_7978;   // "xyz"    @0x0041_0300
    mem[10'h0D0] = 32'h0000_6B6F;   // "ok"     @0x0041_0340
    mem[10'h0E0] = 32'h4443_4241;   // "ABCDEFGH" @0x0041_0380
    mem[10'h0E1] = 32'h4847_4645;
    mem[10'h0F0] = 32'h6463_6261;   // "abcd"   @0x0041_03C0
    mem[10'h3C0] = 32'h4200_0000;   // 'B' at the last legal byte 0x0041_0F03

    repeat (2) @(posedge clk);
    #1;
    chk("reset char_valid", char_valid, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    cpu_mem_read = 1'b1;
    cpu_addr = 32'h0041_0100;
    #1;
    chk("idle pass read", mem_read, 1);
    chk("idle pass addr", mem_addr, 32'h0041_0100);
    chk("idle stall", stall_cpu, 0);
    chk("idle err", err, 0);
    chk("idle done", done, 0);
    cpu_mem_read = 1'b0;

    // "Hi" with the console always ready
    char_ready = 1'b1;
    exp_rd.push_back(32'h0041_0200);
    exp_chr.push_back("H"); exp_chr.push_back("i");
    exp_err.push_back(1'b0);
    pulse_start(32'h0041_0200, 0);
    wait_done(0, 20, cyc);
    chk("hi latency", cyc, 5);

    // String crossing a word boundary
    mem[10'h080] = 32'h4100_0000;
    exp_rd.push_back(32'h0041_0200); exp_rd.push_back(32'h0041_0204);
    exp_chr.push_back("A");
    exp_err.push_back(1'b0);
    pulse_start(32'h0041_0203, 0);
    wait_done(0, 20, cyc);
    chk("cross latency", cyc, 5);

    // CPU owns the port for four FETCH cycles
    exp_rd.push_back(32'h0041_0300);
    exp_chr.push_back("x"); exp_chr.push_back("y"); exp_chr.push_back("z");
    exp_err.push_back(1'b0);
    @(posedge clk); #1;
    a0 = 32'h0041_0300;
    start = 1'b1;
    cpu_mem_write = 1'b1;
    cpu_addr = 32'h0041_0010;
    cpu_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cpu wr mem_write", mem_write, 1);
      chk("cpu wr mem_read", mem_read, 0);
      chk("cpu wr addr", mem_addr, 32'h0041_0010);
      chk("cpu wr wdata", mem_wdata, 32'h1234_5678);
      chk("cpu wr stall", stall_cpu, 1);
    end
    @(posedge clk); #1;
    cpu_mem_write = 1'b0;
    @(negedge clk);
    chk("fetch after release", mem_read, 1);
    @(negedge clk);
    chk("first char after fetch", char_valid, 1);
    wait_done(0, 20, cyc);

    // Console back-pressure on the first character
    char_ready = 1'b0;
    exp_rd.push_back(32'h0041_0340);
    exp_chr.push_back("o"); exp_chr.push_back("k");
    exp_err.push_back(1'b0);
    pulse_start(32'h0041_0340, 0);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid", char_valid, 1);
      chk("hold data", char_data, 32'h6F);
    end
    @(posedge clk); #1;
    char_ready = 1'b1;
    wait_done(0, 20, cyc);

    // Out-of-range start address
    exp_err.push_back(1'b1);
    pulse_start(32'h0000_1000, 0);
    wait_done(0, 10, cyc);
    chk("bad addr latency", cyc, 2);

    // Last legal byte, then the pointer steps past DATA_END
    exp_rd.push_back(32'h0041_0F00);
    exp_chr.push_back("B");
    exp_err.push_back(1'b1);
    pulse_start(32'h0041_0F03, 0);
    wait_done(0, 10, cyc);
    chk("end bound latency", cyc, 4);

    // MAX_LEN=4 instance on an 8-character string
    exp4_chr.push_back("A"); exp4_chr.push_back("B");
    exp4_chr.push_back("C"); exp4_chr.push_back("D");
    exp4_err.push_back(1'b1);
    pulse_start(32'h0041_0380, 1);
    wait_done(1, 20, cyc);
    chk("maxlen latency", cyc, 6);

    // Reset in the middle of EMIT, then a clean walk
    char_ready = 1'b0;
    exp_rd.push_back(32'h0041_03C0);
    pulse_start(32'h0041_03C0, 0);
    wait_valid(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst char_valid", char_valid, 0);
    chk("rst char_data", char_data, 0);
    chk("rst busy", busy, 0);
    chk("rst stall", stall_cpu, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    char_ready = 1'b1;
    exp_rd.push_back(32'h0041_0340);
    exp_chr.push_back("o"); exp_chr.push_back("k");
    exp_err.push_back(1'b0);
    pulse_start(32'h0041_0340, 0);
    wait_done(0, 20, cyc);
    chk("post-reset latency", cyc, 5);

    repeat (3) @(negedge clk);
    chk("leftover chars", exp_chr.size(), 0);
    chk("leftover reads", exp_rd.size(), 0);
    chk("leftover dones", exp_err.size(), 0);
    chk("leftover chars4", exp4_chr.size(), 0);
    chk("leftover dones4", exp4_err.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
